dot_product_ctrl: RTL and testbench
===================================

# dot_product_ctrl

Sequencer for the dot-product datapath: on a start pulse it streams addresses 0..N-1 to two operand memories (registered-read, one-cycle latency, read-enable gated) and accumulates the element-wise products through a pipelined multiply-accumulate. It returns the sum with a one-cycle done pulse. It sits between the FIFO/write side, which fills the operand memories, and the result consumer. While running it locks the memories against writes.

## Interface
- DATA_WIDTH, 32, operand width
- ADDR_WIDTH, 5, memory address width; max vector length 2**ADDR_WIDTH
- ACC_WIDTH, 2*DATA_WIDTH+ADDR_WIDTH, accumulator/result width
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  request a dot product; sampled only in IDLE
- length  in  ADDR_WIDTH+1  element count N, latched on accepted start
- abort  in  1  synchronous cancel, returns to IDLE without done
- rd_en  out  1  read enable, shared by both operand memories
- rd_addr  out  ADDR_WIDTH  read address, shared
- a_data  in  DATA_WIDTH  operand A, valid the cycle after rd_en
- b_data  in  DATA_WIDTH  operand B, valid the cycle after rd_en
- mem_lock  out  1  equals busy; writers must not write while high
- busy  out  1  operation in progress
- done  out  1  one-cycle pulse, result valid
- result  out  ACC_WIDTH  last completed sum, held until the next done

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - start=1, length≠0 → latch N, clear accumulator and address counter → RUN.
  - start=1, length=0 → DONE with result=0, no reads.
  - length > 2**ADDR_WIDTH is clamped to 2**ADDR_WIDTH.
- RUN: rd_en=1, rd_addr=k on the k-th RUN cycle (k=0..N-1). After issuing N-1 → DRAIN.
- Pipeline:
  - stage 1: memory data return (valid flag v1 = rd_en delayed 1).
  - stage 2: product register p = a_data*b_data (v2).
  - stage 3: acc += p when v2.
- DRAIN: two cycles, flushing stages 2–3. rd_en=0. → DONE.
- DONE: result ← acc, done=1 for one cycle → IDLE.
- Arithmetic:
  - Product is 2*DATA_WIDTH bits, extended to ACC_WIDTH.
  - Accumulation is modulo 2**ACC_WIDTH; no overflow is possible for N ≤ 2**ADDR_WIDTH.
- start while busy is ignored, with no queuing.
- abort in any non-IDLE state:
  - next state IDLE; pipeline valids cleared; result unchanged; no done.
  - abort in IDLE has no effect. abort has priority over start in the same cycle.
- Reset values (asynchronous): state=IDLE, rd_en=0, rd_addr=0, busy=0, mem_lock=0, done=0, result=0, acc=0, pipeline valids=0.
- Reset mid-operation: everything clears immediately; no done is produced.

## Timing
- Start accepted in cycle 0. rd_en high in cycles 1..N with rd_addr 0..N-1.
- Cycles N+1, N+2: DRAIN. done and new result in cycle N+3. busy high in cycles 1..N+3.
- Next start is accepted in cycle N+4. Total latency N+3; throughput one element per cycle.
- length=0: busy and done in cycle 1; next start accepted in cycle 2.
- rd_en/rd_addr are registered outputs. The memories must have exactly one-cycle registered read latency.

## Configuration
- DOTP_SIGNED_EN defined:
  - a_data, b_data are two's-complement.
  - Product is a signed multiply, sign-extended to ACC_WIDTH.
  - result is signed.
- Undefined: unsigned multiply, zero-extended, result unsigned.

## Structure
- Package dotp_pkg:
  - state enum (IDLE, RUN, DRAIN, DONE)
  - default width constants
  - localparam for the DRAIN cycle count (2)
- One sub-module, dotp_mac: product register, accumulator, clear/enable/valid pipeline, and the DOTP_SIGNED_EN choice.
- The top holds the FSM, address counter and result register.

## Test plan
- N=4, A={1,2,3,4}, B={5,6,7,8}:
  - rd_addr 0..3 in cycles 1..4; done in cycle 7; result=70; busy cycles 1..7.
- N=32, all A=B=0xFFFFFFFF, unsigned build → result = 32*(2**32-1)**2, no wrap. Same data with DOTP_SIGNED_EN → result=32.
- length=0 → done in cycle 1, result=0, rd_en never asserted.
- abort asserted in cycle 3 of an N=8 run:
  - IDLE in cycle 4; no done; result keeps the previous value (70).
  - A new start in cycle 4 runs normally.
- start pulsed in cycle 2 of a running N=4 job → ignored; exactly one done, in cycle 7.
- rst_n deasserted asynchronously mid-RUN → all outputs 0 immediately. After release, an N=2 run {3,4}·{5,6} gives result=39.

Source files
------------

// File: rtl/dotp_pkg.sv
// Shared types and default widths for the dot-product sequencer and its MAC.
// Optional build macro DOTP_SIGNED_EN selects two's-complement operands in dotp_mac.
package dotp_pkg;

  localparam int DOTP_DATA_WIDTH = 32;
  localparam int DOTP_ADDR_WIDTH = 5;
  localparam int DRAIN_CYCLES    = 2;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

endpackage

// File: rtl/dotp_mac.sv
// Pipelined multiply-accumulate: product register, accumulator and valid pipeline.
// DOTP_SIGNED_EN defined: signed multiply with sign extension; otherwise unsigned.
module dotp_mac
  import dotp_pkg::*;
#(
  parameter int DATA_WIDTH = DOTP_DATA_WIDTH,
  parameter int ACC_WIDTH  = 2*DOTP_DATA_WIDTH + DOTP_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  flush,
  input  logic                  rd_en,
  input  logic [DATA_WIDTH-1:0] a_data,
  input  logic [DATA_WIDTH-1:0] b_data,
  output logic [ACC_WIDTH-1:0]  acc_next
);

  localparam int PW  = 2*DATA_WIDTH;
  localparam int EXT = ACC_WIDTH - PW;

  logic              v1_reg;
  logic              v2_reg;
  logic [PW-1:0]     prod;
  logic [PW-1:0]     p_reg;
  logic [ACC_WIDTH-1:0] p_ext;
  logic [ACC_WIDTH-1:0] acc_reg;

`ifdef DOTP_SIGNED_EN
  assign prod  = $signed({{DATA_WIDTH{a_data[DATA_WIDTH-1]}}, a_data})
               * $signed({{DATA_WIDTH{b_data[DATA_WIDTH-1]}}, b_data});
  assign p_ext = {{EXT{p_reg[PW-1]}}, p_reg};
`else
  assign prod  = {{DATA_WIDTH{1'b0}}, a_data} * {{DATA_WIDTH{1'b0}}, b_data};
  assign p_ext = {{EXT{1'b0}}, p_reg};
`endif

  // Exposed so the sequencer can capture the final sum in the same edge as the last add.
  assign acc_next = v2_reg ? acc_reg + p_ext : acc_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_reg  <= 1'b0;
      v2_reg  <= 1'b0;
      p_reg   <= '0;
      acc_reg <= '0;
    end else begin
      v1_reg <= rd_en & ~flush;
      v2_reg <= v1_reg & ~flush;
      if (v1_reg) begin
        p_reg <= prod;
      end
      acc_reg <= clr ? '0 : acc_next;
    end
  end

endmodule

// File: rtl/dot_product_ctrl.sv
// Dot-product sequencer: streams addresses to both operand memories and returns the sum.
// Operand signedness follows build macro DOTP_SIGNED_EN (see dotp_mac).
module dot_product_ctrl
  import dotp_pkg::*;
#(
  parameter int DATA_WIDTH = DOTP_DATA_WIDTH,
  parameter int ADDR_WIDTH = DOTP_ADDR_WIDTH,
  parameter int ACC_WIDTH  = 2*DATA_WIDTH + ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   length,
  input  logic                  abort,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] a_data,
  input  logic [DATA_WIDTH-1:0] b_data,
  output logic                  mem_lock,
  output logic                  busy,
  output logic                  done,
  output logic [ACC_WIDTH-1:0]  result
);

  localparam logic [ADDR_WIDTH:0] MAX_LEN = {1'b1, {ADDR_WIDTH{1'b0}}};

  state_t                state_reg, state_next;
  logic [ADDR_WIDTH-1:0] addr_reg, addr_next;
  logic [ADDR_WIDTH:0]   n_reg, n_next;
  logic [ADDR_WIDTH:0]   last_addr;
  logic [1:0]            drain_reg, drain_next;
  logic [ACC_WIDTH-1:0]  result_reg, result_next;
  logic [ACC_WIDTH-1:0]  acc_next;
  logic                  rd_en_reg, rd_en_next;
  logic                  mac_clr;
  logic                  mac_flush;

  assign last_addr = n_reg - (ADDR_WIDTH+1)'(1);

  always_comb begin
    state_next  = state_reg;
    addr_next   = addr_reg;
    n_next      = n_reg;
    drain_next  = drain_reg;
    result_next = result_reg;
    mac_clr     = 1'b0;
    mac_flush   = 1'b0;
    case (state_reg)
      IDLE: begin
        // abort outranks start when both arrive together
        if (start && !abort) begin
          if (length == '0) begin
            result_next = '0;
            state_next  = DONE;
          end else begin
            n_next     = (length > MAX_LEN) ? MAX_LEN : length;
            addr_next  = '0;
            mac_clr    = 1'b1;
            state_next = RUN;
          end
        end
      end
      RUN: begin
        if (abort) begin
          addr_next  = '0;
          mac_flush  = 1'b1;
          state_next = IDLE;
        end else if ({1'b0, addr_reg} == last_addr) begin
          drain_next = '0;
          state_next = DRAIN;
        end else begin
          addr_next = addr_reg + ADDR_WIDTH'(1);
        end
      end
      DRAIN: begin
        if (abort) begin
          mac_flush  = 1'b1;
          state_next = IDLE;
        end else if (drain_reg == 2'(DRAIN_CYCLES - 1)) begin
          result_next = acc_next;
          state_next  = DONE;
        end else begin
          drain_next = drain_reg + 2'd1;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign rd_en_next = (state_next == RUN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      addr_reg   <= '0;
      n_reg      <= '0;
      drain_reg  <= '0;
      result_reg <= '0;
      rd_en_reg  <= 1'b0;
    end else begin
      state_reg  <= state_next;
      addr_reg   <= addr_next;
      n_reg      <= n_next;
      drain_reg  <= drain_next;
      result_reg <= result_next;
      rd_en_reg  <= rd_en_next;
    end
  end

  assign rd_en    = rd_en_reg;
  assign rd_addr  = addr_reg;
  assign busy     = (state_reg != IDLE);
  assign mem_lock = busy;
  assign done     = (state_reg == DONE);
  assign result   = result_reg;

  dotp_mac #(
    .DATA_WIDTH(DATA_WIDTH),
    .ACC_WIDTH (ACC_WIDTH)
  ) u_mac (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (mac_clr),
    .flush   (mac_flush),
    .rd_en   (rd_en_reg),
    .a_data  (a_data),
    .b_data  (b_data),
    .acc_next(acc_next)
  );

endmodule

// File: tb/tb_dot_product_ctrl.sv
// Directed bench for dot_product_ctrl with a cycle-level job model and operand memories.
module tb_dot_product_ctrl;

  localparam int DW   = 32;
  localparam int AW   = 5;
  localparam int ACCW = 2*DW + AW;
  localparam int MAXN = 1 << AW;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic            abort = 1'b0;
  logic [AW:0]     length = '0;
  logic            rd_en;
  logic [AW-1:0]   rd_addr;
  logic [DW-1:0]   a_data = '0;
  logic [DW-1:0]   b_data = '0;
  logic            mem_lock;
  logic            busy;
  logic            done;
  logic [ACCW-1:0] result;

  dot_product_ctrl dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .length  (length),
    .abort   (abort),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .a_data  (a_data),
    .b_data  (b_data),
    .mem_lock(mem_lock),
    .busy    (busy),
    .done    (done),
    .result  (result)
  );

  always #5 clk = ~clk;

  // Operand memories with one-cycle registered read
  logic [DW-1:0] mem_a [MAXN];
  logic [DW-1:0] mem_b [MAXN];
  always @(posedge clk) begin
    if (rd_en) begin
      a_data <= mem_a[rd_addr];
      b_data <= mem_b[rd_addr];
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [ACCW-1:0] act, input logic [ACCW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Job model: one accepted job, described by its start cycle, length and abort cycle
  bit              job_valid = 1'b0;
  int              job_t0 = 0;
  int              job_n = 0;
  int              job_last = 0;
  int              job_ta = 0;
  logic [ACCW-1:0] job_sum = '0;
  logic [ACCW-1:0] model_result = '0;

  function automatic logic [ACCW-1:0] dot(input int n);
    logic [ACCW-1:0] s, x, y;
    s = '0;
    for (int i = 0; i < n; i++) begin
`ifdef DOTP_SIGNED_EN
      x = {{(ACCW-DW){mem_a[i][DW-1]}}, mem_a[i]};
      y = {{(ACCW-DW){mem_b[i][DW-1]}}, mem_b[i]};
`else
      x = {{(ACCW-DW){1'b0}}, mem_a[i]};
      y = {{(ACCW-DW){1'b0}}, mem_b[i]};
`endif
      s = s + x * y;
    end
    return s;
  endfunction

  function automatic int job_end();
    return (job_ta < job_t0 + job_last) ? job_ta : job_t0 + job_last;
  endfunction

  function automatic bit model_busy(input int t);
    return job_valid && (t - job_t0 >= 1) && (t <= job_end());
  endfunction

  bit e_busy, e_rd, e_done;
  int rel;
  int done_count = 0;
  int done_cycle = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_rd_en", rd_en, 0);
      chk("rst_rd_addr", rd_addr, 0);
      chk("rst_busy", busy, 0);
      chk("rst_mem_lock", mem_lock, 0);
      chk("rst_done", done, 0);
      chk("rst_result", result, 0);
    end else begin
      rel    = cyc - job_t0;
      e_busy = model_busy(cyc);
      e_rd   = job_valid && job_n > 0 && rel >= 1 && rel <= job_n && cyc <= job_end();
      e_done = job_valid && rel == job_last && job_ta >= cyc;
      chk("busy", busy, e_busy);
      chk("mem_lock", mem_lock, e_busy);
      chk("rd_en", rd_en, e_rd);
      chk("done", done, e_done);
      chk("result", result, e_done ? job_sum : model_result);
      if (e_rd) chk("rd_addr", rd_addr, rel - 1);
      if (done) begin
        done_count++;
        done_cycle = cyc;
      end
      if (e_done) begin
        model_result = job_sum;
        $display("job n=%0d start=%0d done=%0d result=%0h", job_n, job_t0, cyc, job_sum);
      end
    end
  end

  // Called just after a rising edge; start is sampled at the next one.
  task automatic start_now(input int len, output int t0);
    start  = 1'b1;
    length = len[AW:0];
    t0     = cyc;
    if (!model_busy(cyc) && !abort) begin
      job_valid = 1'b1;
      job_t0    = cyc;
      job_n     = (len > MAXN) ? MAXN : len;
      job_last  = (job_n == 0) ? 1 : job_n + 3;
      job_ta    = 1 << 30;
      job_sum   = dot(job_n);
    end
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int t0, tdummy;
  logic [ACCW-1:0] big;

  initial begin
    for (int i = 0; i < MAXN; i++) begin
      mem_a[i] = '0;
      mem_b[i] = '0;
    end
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    step(1);

    // N=4 with a start pulse in cycle 2 that must be ignored
    for (int i = 0; i < 4; i++) begin
      mem_a[i] = DW'(i + 1);
      mem_b[i] = DW'(i + 5);
    end
    done_count = 0;
    start_now(4, t0);
    step(1);
    start_now(4, tdummy);
    step(8);
    chk("n4_result", result, 70);
    chk("n4_done_latency", done_cycle - t0, 7);
    chk("n4_done_count", done_count, 1);

    // N=8 aborted in cycle 3, then restarted in cycle 4
    for (int i = 0; i < 8; i++) begin
      mem_a[i] = DW'(i + 1);
      mem_b[i] = 2;
    end
    done_count = 0;
    start_now(8, t0);
    step(2);
    abort = 1'b1;
    if (model_busy(cyc)) job_ta = cyc;
    step(1);
    abort = 1'b0;
    chk("abort_idle_busy", busy, 0);
    chk("abort_result_kept", result, 70);
    start_now(8, t0);
    step(12);
    chk("restart_result", result, 72);
    chk("restart_done_count", done_count, 1);
    chk("restart_done_latency", done_cycle - t0, 11);

    // length=0
    done_count = 0;
    start_now(0, t0);
    step(3);
    chk("len0_result", result, 0);
    chk("len0_done_latency", done_cycle - t0, 1);
    chk("len0_done_count", done_count, 1);

    // N=32 all ones
    for (int i = 0; i < MAXN; i++) begin
      mem_a[i] = '1;
      mem_b[i] = '1;
    end
    start_now(32, t0);
    step(40);
`ifdef DOTP_SIGNED_EN
    big = 32;
`else
    big = ACCW'(32) * ((ACCW'(1) << 32) - ACCW'(1)) * ((ACCW'(1) << 32) - ACCW'(1));
`endif
    chk("n32_result", result, big);
    chk("n32_done_latency", done_cycle - t0, 35);

    // length 40 clamps to 32
    for (int i = 0; i < MAXN; i++) begin
      mem_a[i] = DW'(i);
      mem_b[i] = 1;
    end
    start_now(40, t0);
    step(40);
    chk("clamp_result", result, 496);
    chk("clamp_done_latency", done_cycle - t0, 35);

    // asynchronous reset mid-RUN, then N=2
    start_now(4, t0);
    @(posedge clk);
    #3 rst_n = 1'b0;
    job_valid    = 1'b0;
    model_result = '0;
    #1;
    chk("async_rd_en", rd_en, 0);
    chk("async_busy", busy, 0);
    chk("async_rd_addr", rd_addr, 0);
    chk("async_result", result, 0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    step(1);
    mem_a[0] = 3; mem_a[1] = 4;
    mem_b[0] = 5; mem_b[1] = 6;
    done_count = 0;
    start_now(2, t0);
    step(8);
    chk("post_reset_result", result, 39);
    chk("post_reset_done_latency", done_cycle - t0, 5);
    chk("post_reset_done_count", done_count, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
